switch_conditioner: RTL and testbench

Input-conditioning stage directly upstream of the picoMIPS ALU's `switches[8:0]` operand input. It synchronises and debounces the nine raw board switches, drives the clean `switches` bus into the ALU's `SW_7_0`/`SW_8` operand selects, and runs a small SW8 handshake FSM. The FSM snapshots the data switches on each SW8 press and holds a sticky valid/overrun status until the processor acknowledges it.

---
 rtl/switch_conditioner.sv | 148 ++++++++++++++
 tb/tb_switch_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// Switch input conditioner for the picoMIPS ALU operand bus: two-flop
// synchronisers, per-bit debouncers and an SW8 press/ack handshake.

module switch_conditioner_lane #(
    parameter int DEBOUNCE = 50000,
    parameter int CW       = $clog2(DEBOUNCE)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o
);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised level disagrees with the
    // accepted one; any agreement restarts the count, so it cannot wrap.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

module switch_conditioner #(
    parameter int n        = 8,
    parameter int DEBOUNCE = 50000,
    localparam int CW      = $clog2(DEBOUNCE)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n:0]   sw_raw,
    input  logic         ack,
    output logic [n:0]   switches,
    output logic [n-1:0] data_latched,
    output logic         press,
    output logic         release_o,
    output logic         data_valid,
    output logic         overrun
);

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

    state_t         state_q, state_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic [n-1:0]   latched_q, latched_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;
    logic [n:0]     level;

    for (genvar i = 0; i <= n; i++) begin : g_lane
        switch_conditioner_lane #(
            .DEBOUNCE(DEBOUNCE),
            .CW      (CW)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .raw_i  (sw_raw[i]),
            .level_o(level[i])
        );
    end

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        latched_d = latched_q;
        case (state_q)
            IDLE: if (level[n]) begin
                press_d   = 1'b1;
                latched_d = level[n-1:0];
                state_d   = HELD;
            end
            HELD: if (!level[n]) begin
                release_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A press on the same edge as ack wins; the ack retires the old data,
    // so it cannot count towards an overrun.
    always_comb begin
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (press_d) begin
            valid_d   = 1'b1;
            overrun_d = ack ? 1'b0 : (overrun_q | valid_q);
        end else if (ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            latched_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            latched_q <= latched_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign switches     = level;
    assign data_latched = latched_q;
    assign press        = press_q;
    assign release_o    = release_q;
    assign data_valid   = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Self-checking bench for switch_conditioner: vector table, directed corner
// sequences and randomized stimulus against a sample-window reference model.

module tb_switch_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] sw_raw = '0;
    logic       ack = 1'b0;
    logic [8:0] switches;
    logic [7:0] data_latched;
    logic       press, rel_o, data_valid, overrun;

    int tests = 0;
    int fails = 0;
    int pcount = 0;
    int rcount = 0;

    switch_conditioner #(.n(8), .DEBOUNCE(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .ack         (ack),
        .switches    (switches),
        .data_latched(data_latched),
        .press       (press),
        .release_o   (rel_o),
        .data_valid  (data_valid),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: hist[j] is the raw value sampled j+1 edges ago.
    // A bit is accepted once every synchronised sample in the last D edges
    // disagrees with the accepted level.
    logic [8:0] m_hist [0:D];
    logic [8:0] m_sw;
    logic [7:0] m_lat;
    logic       m_held, m_press, m_rel, m_valid, m_ovr;

    function automatic logic [20:0] pk(logic [8:0] s, logic [7:0] l, logic p,
                                       logic r, logic v, logic o);
        return {s, l, p, r, v, o};
    endfunction

    task automatic model_step(input logic r, input logic [8:0] raw, input logic a);
        logic [8:0] old_sw;
        logic       all_diff;
        if (r) begin
            for (int j = 0; j <= D; j++) m_hist[j] = '0;
            m_sw = '0; m_lat = '0; m_held = 0; m_press = 0; m_rel = 0;
            m_valid = 0; m_ovr = 0;
            return;
        end
        old_sw = m_sw;
        for (int b = 0; b < 9; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
                if (m_hist[j][b] == old_sw[b]) all_diff = 1'b0;
            if (all_diff) m_sw[b] = ~old_sw[b];
        end
        m_press = !m_held && old_sw[8];
        m_rel   = m_held && !old_sw[8];
        if (m_press) begin
            m_held  = 1'b1;
            m_lat   = old_sw[7:0];
            m_ovr   = a ? 1'b0 : (m_ovr | m_valid);
            m_valid = 1'b1;
        end else begin
            if (m_rel) m_held = 1'b0;
            if (a) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
        end
        for (int j = D; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = raw;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One active edge: drive at the falling edge, check after the next one.
    task automatic cyc(input logic r, input logic [8:0] raw, input logic a);
        reset = r; sw_raw = raw; ack = a;
        model_step(r, raw, a);
        @(negedge clk);
        if (press === 1'b1) pcount++;
        if (rel_o === 1'b1) rcount++;
        chk("model", 32'(pk(switches, data_latched, press, rel_o, data_valid, overrun)),
            32'(pk(m_sw, m_lat, m_press, m_rel, m_valid, m_ovr)));
    endtask

    task automatic hold(input logic [8:0] raw, input logic a, input int cycles);
        for (int k = 0; k < cycles; k++) cyc(1'b0, raw, a);
    endtask

    task automatic do_reset();
        cyc(1'b1, 9'h000, 1'b0);
        cyc(1'b1, 9'h000, 1'b0);
    endtask

    typedef struct {
        logic       rst;
        logic [8:0] raw;
        logic       a;
        logic [8:0] e_sw;
        logic       e_press;
        logic       e_valid;
        logic [7:0] e_lat;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [8:0] raw, logic a, logic [8:0] e_sw,
                                logic e_press, logic e_valid, logic [7:0] e_lat);
        vec_t v;
        v.rst = rst; v.raw = raw; v.a = a; v.e_sw = e_sw;
        v.e_press = e_press; v.e_valid = e_valid; v.e_lat = e_lat;
        return v;
    endfunction

    initial begin
        logic [8:0] r;
        int         len;

        // Reset mid-count, then a held 9'h1FF debounces into a fresh press.
        tbl.push_back(mk(1, 9'h000, 0, 9'h000, 0, 0, 8'h00));
        tbl.push_back(mk(0, 9'h1FF, 0, 9'h000, 0, 0, 8'h00));
        tbl.push_back(mk(0, 9'h1FF, 0, 9'h000, 0, 0, 8'h00));
        tbl.push_back(mk(0, 9'h1FF, 0, 9'h000, 0, 0, 8'h00));
        tbl.push_back(mk(1, 9'h1FF, 0, 9'h000, 0, 0, 8'h00));
        tbl.push_back(mk(1, 9'h1FF, 0, 9'h000, 0, 0, 8'h00));
        for (int e = 1; e <= 5; e++) tbl.push_back(mk(0, 9'h1FF, 0, 9'h000, 0, 0, 8'h00));
        tbl.push_back(mk(0, 9'h1FF, 0, 9'h1FF, 0, 0, 8'h00));
        tbl.push_back(mk(0, 9'h1FF, 0, 9'h1FF, 1, 1, 8'hFF));
        tbl.push_back(mk(0, 9'h1FF, 0, 9'h1FF, 0, 1, 8'hFF));
        tbl.push_back(mk(0, 9'h1FF, 1, 9'h1FF, 0, 0, 8'hFF));
        tbl.push_back(mk(0, 9'h0FF, 0, 9'h1FF, 0, 0, 8'hFF));

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].raw, tbl[i].a);
            chk($sformatf("tbl[%0d]", i),
                32'(pk(switches, data_latched, press, rel_o, data_valid, overrun)),
                32'(pk(tbl[i].e_sw, tbl[i].e_lat, tbl[i].e_press, 1'b0, tbl[i].e_valid, 1'b0)));
        end

        // Clean press and release.
        do_reset();
        hold(9'h0A5, 0, 8);
        chk("t2_settle", 32'(switches), 32'h0A5);
        pcount = 0; rcount = 0;
        hold(9'h1A5, 0, 5);
        chk("t2_sw8_e5", 32'(switches[8]), 32'h0);
        cyc(0, 9'h1A5, 0);
        chk("t2_sw8_e6", 32'({switches[8], press}), 32'h2);
        cyc(0, 9'h1A5, 0);
        chk("t2_press", 32'({press, data_valid, data_latched}), 32'h3A5);
        hold(9'h1A5, 0, 3);
        chk("t2_one_press", 32'(pcount), 32'd1);
        hold(9'h0A5, 0, 8);
        chk("t2_one_release", 32'(rcount), 32'd1);

        // Bounce rejection.
        do_reset();
        hold(9'h000, 0, 6);
        pcount = 0;
        cyc(0, 9'h100, 0); cyc(0, 9'h000, 0); cyc(0, 9'h100, 0); cyc(0, 9'h000, 0);
        hold(9'h100, 0, 5);
        chk("t3_no_press", 32'(pcount), 32'd0);
        hold(9'h100, 0, 8);
        chk("t3_one_press", 32'(pcount), 32'd1);

        // Overrun, then ack clears the flags but not the data.
        do_reset();
        hold(9'h011, 0, 8); hold(9'h111, 0, 8); hold(9'h011, 0, 8);
        hold(9'h022, 0, 8); hold(9'h122, 0, 8);
        chk("t4_overrun", 32'({overrun, data_valid, data_latched}), 32'h322);
        cyc(0, 9'h122, 1);
        chk("t4_ack", 32'({overrun, data_valid, data_latched}), 32'h022);

        // Press and ack on the same edge.
        do_reset();
        hold(9'h055, 0, 8); hold(9'h155, 0, 8); hold(9'h055, 0, 8);
        hold(9'h066, 0, 8);
        chk("t5_pre", 32'({overrun, data_valid}), 32'h1);
        hold(9'h166, 0, 6);
        chk("t5_no_press_yet", 32'(press), 32'h0);
        cyc(0, 9'h166, 1);
        chk("t5_collision", 32'({press, overrun, data_valid, data_latched}), 32'h566);

        // Data changed too late is captured at its old value.
        do_reset();
        hold(9'h000, 0, 8);
        hold(9'h100, 0, 2);
        hold(9'h13C, 0, 5);
        chk("t6_press", 32'({press, data_latched}), 32'h100);
        hold(9'h13C, 0, 3);
        chk("t6_late", 32'({switches[7:0], data_latched}), 32'h3C00);

        // Randomized segments with occasional ack and reset.
        do_reset();
        r = '0;
        for (int s = 0; s < 300; s++) begin
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 2) != 0) r = {r[8], 8'($urandom)};
            else r = 9'($urandom);
            for (int j = 0; j < len; j++)
                cyc(($urandom_range(0, 199) == 0), r, ($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
